kf_pic_multichannel: RTL and testbench

- Parametrised next-generation programmable interrupt controller: NUM_IRQ request lines, per-channel edge/level trigger select, mask register, in-service tracking with fully-nested priority, and programmable rotating priority.
- Adds auto-EOI, specific/non-specific EOI with optional rotation, and a vector base register.
- Drives the CPU interrupt line and returns a vector through a registered acknowledge handshake.
- Sits on the system register bus alongside the other peripherals.

---
 rtl/kf_pic_multichannel.sv | 234 +++++++++++++++++++++++
 tb/tb_kf_pic_multichannel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_pic_multichannel.sv
// Programmable interrupt controller: edge/level capture, mask, fully-nested
// in-service tracking with rotating priority, EOI handling and a registered vector handshake.
module kf_pic_multichannel #(
  parameter int NUM_IRQ      = 16,
  parameter int ID_WIDTH     = 4,
  parameter int VECTOR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    chip_select,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [2:0]              address,
  input  logic [NUM_IRQ-1:0]      data_bus_in,
  output logic [NUM_IRQ-1:0]      data_bus_out,
  input  logic [NUM_IRQ-1:0]      interrupt_request,
  output logic                    interrupt_to_cpu,
  input  logic                    interrupt_acknowledge,
  output logic                    vector_valid,
  output logic [VECTOR_WIDTH-1:0] vector,
  output logic [ID_WIDTH-1:0]     vector_id,
  output logic                    spurious
);

  localparam int RW       = ID_WIDTH + 1;
  localparam int ID_RANGE = 1 << ID_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [NUM_IRQ-1:0]      imr_q, imr_d, trig_q, trig_d;
  logic [NUM_IRQ-1:0]      irr_q, irr_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0]      prev_q, blk_q, blk_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic [VECTOR_WIDTH-1:0] vbase_q, vbase_d;
  logic [ID_WIDTH-1:0]     lp_q, lp_d;
  logic [NUM_IRQ-1:0]      dout_q, dout_d;
  logic                    int_q, int_d, vv_q, vv_d, spur_q, spur_d;
  logic [VECTOR_WIDTH-1:0] vec_q, vec_d;
  logic [ID_WIDTH-1:0]     vid_q, vid_d;

  logic                    wr_en, rd_en;
  logic [NUM_IRQ-1:0]      elig;
  logic                    win_vld, isr_any;
  logic [ID_WIDTH-1:0]     win_id, isr_top;
  logic [RW-1:0]           win_rank, isr_rank;

  assign wr_en = chip_select & write_enable;
  assign rd_en = chip_select & read_enable;
  assign elig  = irr_q & ~imr_q;

  // Walk ranks from lowest to highest so the highest-ranked hit is the last one assigned.
  always_comb begin
    int ch;
    logic [ID_WIDTH-1:0] chi;
    ch       = 0;
    chi      = '0;
    win_vld  = 1'b0;
    win_id   = '0;
    win_rank = RW'(NUM_IRQ);
    isr_any  = 1'b0;
    isr_top  = '0;
    isr_rank = RW'(NUM_IRQ);
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      ch = int'(lp_q) + 1 + k;
      if (ch >= NUM_IRQ) ch = ch - NUM_IRQ;
      chi = ID_WIDTH'(ch);
      if (elig[chi]) begin
        win_vld  = 1'b1;
        win_id   = chi;
        win_rank = RW'(k);
      end
      if (isr_q[chi]) begin
        isr_any  = 1'b1;
        isr_top  = chi;
        isr_rank = RW'(k);
      end
    end
  end

  // EOI: ids beyond NUM_IRQ index zero-padding and so never hit.
  logic                eoi_wr, eoi_hit, eoi_rot;
  logic [ID_WIDTH-1:0] eoi_id;
  logic [ID_RANGE-1:0] isr_ext, eoi_clr_ext;
  logic [NUM_IRQ-1:0]  eoi_clr;

  assign eoi_wr  = wr_en && (address == 3'd6);
  assign eoi_rot = data_bus_in[9];
  assign isr_ext = ID_RANGE'(isr_q);

  always_comb begin
    eoi_hit = 1'b0;
    eoi_id  = '0;
    if (eoi_wr) begin
      if (data_bus_in[8]) begin
        eoi_id  = data_bus_in[ID_WIDTH-1:0];
        eoi_hit = isr_ext[eoi_id];
      end else begin
        eoi_id  = isr_top;
        eoi_hit = isr_any;
      end
    end
  end

  assign eoi_clr_ext = eoi_hit ? (ID_RANGE'(1) << eoi_id) : '0;
  assign eoi_clr     = NUM_IRQ'(eoi_clr_ext);

  logic               ack_take, ack_hit;
  logic [NUM_IRQ-1:0] win_oh, ack_clr, isr_set;

  assign ack_take = (state_q == S_IDLE) && interrupt_acknowledge;
  assign ack_hit  = ack_take && win_vld;
  assign win_oh   = NUM_IRQ'(1) << win_id;
  assign ack_clr  = ack_hit ? win_oh : '0;
  assign isr_set  = (ack_hit && !ctrl_q[0]) ? win_oh : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (interrupt_acknowledge) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // vector_valid is registered from RESPOND, so a reset during RESPOND suppresses it.
  always_comb begin
    vv_d   = (state_q == S_RESP);
    int_d  = win_vld && (win_rank < isr_rank) &&
             (state_q == S_IDLE) && (state_d == S_IDLE);
    vec_d  = vec_q;
    vid_d  = vid_q;
    spur_d = spur_q;
    if (ack_take) begin
      if (win_vld) begin
        vid_d  = win_id;
        vec_d  = vbase_q + VECTOR_WIDTH'(win_id);
        spur_d = 1'b0;
      end else begin
        vid_d  = ID_WIDTH'(NUM_IRQ - 1);
        vec_d  = vbase_q + VECTOR_WIDTH'(NUM_IRQ - 1);
        spur_d = 1'b1;
      end
    end
  end

  always_comb begin
    imr_d   = imr_q;
    trig_d  = trig_q;
    ctrl_d  = ctrl_q;
    vbase_d = vbase_q;
    if (wr_en) begin
      case (address)
        3'd0:    imr_d   = data_bus_in;
        3'd1:    trig_d  = data_bus_in;
        3'd4:    ctrl_d  = data_bus_in[1:0];
        3'd5:    vbase_d = data_bus_in[VECTOR_WIDTH-1:0];
        default: ;
      endcase
    end
    dout_d = dout_q;
    if (rd_en) begin
      case (address)
        3'd0:    dout_d = imr_q;
        3'd1:    dout_d = trig_q;
        3'd2:    dout_d = irr_q;
        3'd3:    dout_d = isr_q;
        3'd4:    dout_d = NUM_IRQ'(ctrl_q);
        3'd5:    dout_d = NUM_IRQ'(vbase_q);
        default: dout_d = '0;
      endcase
    end
  end

  // Level channels stay blocked after acknowledge until the pin drops.
  always_comb begin
    blk_d = interrupt_request & (blk_q | ack_clr);
    irr_d = (trig_q & interrupt_request & ~(blk_q | ack_clr)) |
            (~trig_q & ((irr_q & ~ack_clr) | (interrupt_request & ~prev_q)));
    isr_d = (isr_q & ~eoi_clr) | isr_set;
    lp_d  = lp_q;
    if (eoi_hit && eoi_rot) lp_d = eoi_id;
    if (ack_hit && ctrl_q[0] && ctrl_q[1]) lp_d = win_id;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imr_q   <= '1;
      trig_q  <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      prev_q  <= '0;
      blk_q   <= '0;
      ctrl_q  <= '0;
      vbase_q <= '0;
      lp_q    <= ID_WIDTH'(NUM_IRQ - 1);
      dout_q  <= '0;
      int_q   <= 1'b0;
      vv_q    <= 1'b0;
      vec_q   <= '0;
      vid_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      imr_q   <= imr_d;
      trig_q  <= trig_d;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      prev_q  <= interrupt_request;
      blk_q   <= blk_d;
      ctrl_q  <= ctrl_d;
      vbase_q <= vbase_d;
      lp_q    <= lp_d;
      dout_q  <= dout_d;
      int_q   <= int_d;
      vv_q    <= vv_d;
      vec_q   <= vec_d;
      vid_q   <= vid_d;
      spur_q  <= spur_d;
    end
  end

  assign data_bus_out     = dout_q;
  assign interrupt_to_cpu = int_q;
  assign vector_valid     = vv_q;
  assign vector           = vec_q;
  assign vector_id        = vid_q;
  assign spurious         = spur_q;

endmodule

// File: tb/tb_kf_pic_multichannel.sv
// Directed bench for kf_pic_multichannel; acknowledge expectations flow through a scoreboard queue.
module tb_kf_pic_multichannel;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        chip_select = 1'b0, write_enable = 1'b0, read_enable = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] data_bus_in = '0;
  logic [15:0] data_bus_out;
  logic [15:0] interrupt_request = '0;
  logic        interrupt_to_cpu;
  logic        interrupt_acknowledge = 1'b0;
  logic        vector_valid;
  logic [7:0]  vector;
  logic [3:0]  vector_id;
  logic        spurious;

  typedef struct packed {
    logic [7:0] vec;
    logic [3:0] id;
    logic       spur;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  kf_pic_multichannel #(.NUM_IRQ(16), .ID_WIDTH(4), .VECTOR_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select),
    .write_enable(write_enable), .read_enable(read_enable), .address(address),
    .data_bus_in(data_bus_in), .data_bus_out(data_bus_out),
    .interrupt_request(interrupt_request), .interrupt_to_cpu(interrupt_to_cpu),
    .interrupt_acknowledge(interrupt_acknowledge), .vector_valid(vector_valid),
    .vector(vector), .vector_id(vector_id), .spurious(spurious)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chip_select = 1'b1; write_enable = 1'b1; address = a; data_bus_in = d;
    tick();
    chip_select = 1'b0; write_enable = 1'b0; data_bus_in = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    chip_select = 1'b1; read_enable = 1'b1; address = a;
    tick();
    chip_select = 1'b0; read_enable = 1'b0;
    chk(tag, data_bus_out, exp);
  endtask

  task automatic pulse(input logic [15:0] m);
    interrupt_request = m;
    tick();
    interrupt_request = '0;
  endtask

  task automatic do_ack(input logic [7:0] v, input logic [3:0] id, input logic sp);
    exp_t e;
    int   n;
    e.vec = v; e.id = id; e.spur = sp;
    sb.push_back(e);
    interrupt_acknowledge = 1'b1;
    tick();
    interrupt_acknowledge = 1'b0;
    chk("int_low_in_respond", interrupt_to_cpu, 1'b0);
    n = 0;
    while (vector_valid !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    chk("vv_seen", vector_valid, 1'b1);
    e = sb.pop_front();
    chk("vector", vector, e.vec);
    chk("vector_id", vector_id, e.id);
    chk("spurious", spurious, e.spur);
    tick();
    chk("vv_one_cycle", vector_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_dout", data_bus_out, 16'h0);
    chk("rst_int", interrupt_to_cpu, 1'b0);
    chk("rst_vv", vector_valid, 1'b0);
    chk("rst_vec", vector, 8'h0);
    chk("rst_vid", vector_id, 4'h0);
    chk("rst_spur", spurious, 1'b0);
    reset_n = 1'b1;
    tick();
    rd_chk("rst_imr", 3'd0, 16'hFFFF);
    rd_chk("rst_trig", 3'd1, 16'h0000);

    // Edge capture and latency
    wr(3'd0, 16'h0000);
    wr(3'd5, 16'h0020);
    rd_chk("vbase", 3'd5, 16'h0020);
    pulse(16'h0008);
    chk("edge_n1_int0", interrupt_to_cpu, 1'b0);
    tick();
    chk("edge_n2_int1", interrupt_to_cpu, 1'b1);
    do_ack(8'h23, 4'd3, 1'b0);
    rd_chk("edge_isr", 3'd3, 16'h0008);
    rd_chk("edge_irr", 3'd2, 16'h0000);

    // Nesting
    pulse(16'h0020);
    tick(); tick();
    chk("nest_irq5_blocked", interrupt_to_cpu, 1'b0);
    rd_chk("nest_irr5", 3'd2, 16'h0020);
    pulse(16'h0002);
    tick();
    chk("nest_irq1_int", interrupt_to_cpu, 1'b1);
    do_ack(8'h21, 4'd1, 1'b0);
    rd_chk("nest_isr_a", 3'd3, 16'h000A);
    chk("nest_int_after", interrupt_to_cpu, 1'b0);
    wr(3'd6, 16'h0000);
    rd_chk("nest_eoi1", 3'd3, 16'h0008);
    chk("nest_int_still0", interrupt_to_cpu, 1'b0);
    wr(3'd6, 16'h0000);
    rd_chk("nest_eoi2", 3'd3, 16'h0000);
    chk("nest_irq5_now", interrupt_to_cpu, 1'b1);
    do_ack(8'h25, 4'd5, 1'b0);
    wr(3'd6, 16'h0000);
    rd_chk("nest_clean", 3'd3, 16'h0000);

    // Rotation
    pulse(16'h0001);
    tick();
    do_ack(8'h20, 4'd0, 1'b0);
    pulse(16'h0005);
    tick(); tick();
    chk("rot_equal_rank_blocked", interrupt_to_cpu, 1'b0);
    wr(3'd6, 16'h0300);
    rd_chk("rot_isr_cleared", 3'd3, 16'h0000);
    chk("rot_int", interrupt_to_cpu, 1'b1);
    do_ack(8'h22, 4'd2, 1'b0);
    rd_chk("rot_irr0_left", 3'd2, 16'h0001);
    wr(3'd6, 16'h0000);
    tick();
    do_ack(8'h20, 4'd0, 1'b0);
    wr(3'd6, 16'h0100);
    // Specific EOI on the top channel, rotating lp back to 15
    pulse(16'h8000);
    tick();
    do_ack(8'h2F, 4'd15, 1'b0);
    rd_chk("eoi15_isr_set", 3'd3, 16'h8000);
    wr(3'd6, 16'h030F);
    rd_chk("eoi15_isr_clr", 3'd3, 16'h0000);

    // Level trigger and mask
    wr(3'd1, 16'h0010);
    interrupt_request = 16'h0010;
    tick(); tick();
    chk("lvl_int", interrupt_to_cpu, 1'b1);
    do_ack(8'h24, 4'd4, 1'b0);
    rd_chk("lvl_irr_blocked", 3'd2, 16'h0000);
    tick(); tick();
    rd_chk("lvl_irr_still_blocked", 3'd2, 16'h0000);
    wr(3'd6, 16'h0000);
    tick();
    chk("lvl_no_int_held", interrupt_to_cpu, 1'b0);
    interrupt_request = 16'h0000;
    tick();
    interrupt_request = 16'h0010;
    tick(); tick();
    chk("lvl_reassert", interrupt_to_cpu, 1'b1);
    rd_chk("lvl_irr_back", 3'd2, 16'h0010);
    wr(3'd0, 16'h0010);
    chk("mask_lag", interrupt_to_cpu, 1'b1);
    tick();
    chk("mask_deassert", interrupt_to_cpu, 1'b0);
    interrupt_request = 16'h0000;
    tick(); tick();
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);

    // Spurious
    tick();
    chk("spur_no_int", interrupt_to_cpu, 1'b0);
    do_ack(8'h2F, 4'd15, 1'b1);
    rd_chk("spur_isr", 3'd3, 16'h0000);

    // Auto-EOI with rotation
    wr(3'd4, 16'h0003);
    rd_chk("ctrl", 3'd4, 16'h0003);
    pulse(16'h0080);
    tick();
    do_ack(8'h27, 4'd7, 1'b0);
    rd_chk("aeoi_isr", 3'd3, 16'h0000);
    pulse(16'h0140);
    tick();
    do_ack(8'h28, 4'd8, 1'b0);
    do_ack(8'h26, 4'd6, 1'b0);
    rd_chk("aeoi_isr2", 3'd3, 16'h0000);
    wr(3'd4, 16'h0000);

    // Reset during RESPOND
    pulse(16'h0008);
    tick();
    interrupt_acknowledge = 1'b1;
    tick();
    interrupt_acknowledge = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstmid_vv", vector_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_vv_hold", vector_valid, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    chk("rstmid_vv_after", vector_valid, 1'b0);
    chk("rstmid_vec", vector, 8'h0);
    rd_chk("rstmid_imr", 3'd0, 16'hFFFF);
    rd_chk("rstmid_isr", 3'd3, 16'h0000);
    rd_chk("reserved_reads0", 3'd7, 16'h0000);
    wr(3'd7, 16'h1234);
    wr(3'd0, 16'h0000);
    wr(3'd5, 16'h0020);
    rd_chk("vbase2", 3'd5, 16'h0020);
    rd_chk("eoi_reads0", 3'd6, 16'h0000);
    pulse(16'h8000);
    tick();
    do_ack(8'h2F, 4'd15, 1'b0);
    rd_chk("b15_isr", 3'd3, 16'h8000);
    wr(3'd6, 16'h010F);
    rd_chk("b15_cleared", 3'd3, 16'h0000);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
